edf_grant_controller: RTL
=========================

// Module: edf_grant_controller
// PURPOSE
//  Earliest-deadline-first grant controller for the per-queue packet buffers of the
//  non-AXI domain. Tracks one periodic relative deadline per queue and picks the
//  non-empty queue with the smallest remaining deadline. Drives the selector index and
//  the serializer activate handshake, then pops the served queue on completion.
//  Sits between the queue empty flags / config registers and the selector + serializer.
// PARAMETERS
//  NUMBER_OF_QUEUES  4   number of queues arbitrated (>=2, power of two)
//  REGISTER_SIZE     32  width of deadline/period config values and counters
// PORTS
//  clock            in   1                    system clock
//  reset            in   1                    async, active-high reset
//  empty            in   NUMBER_OF_QUEUES     queue i holds no packet
//  deadlines        in   NQ x REGISTER_SIZE   relative deadline per queue, in cycles
//  periods          in   NQ x REGISTER_SIZE   period per queue, in cycles; 0 = aperiodic
//  consumed         in   1                    serializer finished the granted packet
//  id               out  clog2(NQ)            selector index of the granted queue
//  enable           out  1                    grant active; serializer may start
//  hasBeenConsumed  out  NUMBER_OF_QUEUES     one-hot 1-cycle pop pulse to queue i
//  deadline_miss    out  NUMBER_OF_QUEUES     1-cycle pulse: queue i period expired while non-empty
// BEHAVIOUR
//  Reset (async): id=0, enable=0, hasBeenConsumed=0, deadline_miss=0, state=IDLE,
//   all period and deadline counters = 0.
//  Per-queue counters (every cycle, independent of FSM):
//   - periods[i]==0: pcnt[i] held 0; dcnt[i] forced to all-ones (least urgent, still served).
//   - pcnt[i]==0 && periods[i]!=0: pcnt<=periods[i]-1, dcnt<=deadlines[i] (release).
//   - otherwise pcnt decrements by 1; dcnt decrements, saturating at 0 (no wrap).
//   - Release with empty[i]==0 && dcnt[i]==0 -> deadline_miss[i] pulses that cycle.
//   - First release occurs on the first clock after reset deassertion.
//  Selection (combinational on registered dcnt/empty): among queues with empty==0,
//   minimum dcnt; ties broken to lowest index. Unsigned REGISTER_SIZE compare.
//  FSM:
//   IDLE : if any empty[i]==0 -> latch id<=winner, enable<=1, go GRANT.
//          Else stay; enable=0.
//   GRANT: id and enable held stable (no preemption by a more urgent queue).
//          consumed=1 -> hasBeenConsumed[id]=1 for exactly 1 cycle, enable<=0, go IDLE.
//          empty[id]=1 without consumed -> abort: enable<=0, no pop, go IDLE.
//          consumed and empty[id] both high -> consumed wins (pop issued).
//  Latency: non-empty queue in IDLE -> enable high on next rising edge. After consumed,
//   one mandatory IDLE cycle (enable=0) before the next grant so the queue head and
//   empty flag settle.
//  consumed in IDLE is ignored. Config changes take effect at the next release only.
//  Reset mid-GRANT: enable and pulses drop immediately (async); no pop issued.
// TESTING
//  1 NQ=4, all periods=0, queues 2,3 non-empty -> grant id=2 (tie, lowest); consumed ->
//    hasBeenConsumed=4'b0100 one cycle; next grant id=3 after 1 idle cycle.
//  2 periods={100,100,100,100}, deadlines={40,10,30,20}, all non-empty -> grant order
//    1,3,2,0 (one packet each, consumed 5 cycles after each enable).
//  3 Queue 0 deadline=5, period=50, held non-empty and never consumed -> dcnt sits at 0,
//    deadline_miss[0] pulses at cycle 51 after reset release, then every 50 cycles.
//  4 During GRANT of id=1, queue 0 becomes more urgent -> id stays 1 until consumed;
//    queue 0 granted next.
//  5 GRANT id=2, force empty[2]=1 with consumed=0 -> enable drops next cycle,
//    hasBeenConsumed stays 0, FSM back to IDLE.
//  6 Assert reset while enable=1 -> enable, id, hasBeenConsumed go 0 without a clock edge;
//    first release and grant resume after deassertion.

Source files
------------

// File: rtl/edf_grant_controller.sv
// Earliest-deadline-first grant controller: per-queue periodic deadline tracking,
// minimum-remaining-deadline selection and a grant/consume handshake with the serializer.
module edf_grant_controller #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [NUMBER_OF_QUEUES-1:0]                         empty,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]      deadlines,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]      periods,
  input  logic                                                consumed,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]                 id,
  output logic                                                enable,
  output logic [NUMBER_OF_QUEUES-1:0]                         hasBeenConsumed,
  output logic [NUMBER_OF_QUEUES-1:0]                         deadline_miss
);

  localparam int ID_WIDTH = $clog2(NUMBER_OF_QUEUES);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                           state;
  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   dcnt;
  logic [ID_WIDTH-1:0]                              winner;
  logic [REGISTER_SIZE-1:0]                         best;
  logic                                             found;

  for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_queue
    logic [REGISTER_SIZE-1:0] pcnt_q;
    logic [REGISTER_SIZE-1:0] dcnt_q;
    logic                     armed_q;
    logic                     miss_q;

    // armed_q keeps the reset value of dcnt (0) from being reported as a miss
    // at the very first release, when no deadline was ever running.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pcnt_q  <= '0;
        dcnt_q  <= '0;
        armed_q <= 1'b0;
        miss_q  <= 1'b0;
      end else begin
        miss_q <= 1'b0;
        if (periods[gi] == '0) begin
          pcnt_q <= '0;
          dcnt_q <= '1;
        end else if (pcnt_q == '0) begin
          pcnt_q  <= periods[gi] - REGISTER_SIZE'(1);
          dcnt_q  <= deadlines[gi];
          armed_q <= 1'b1;
          miss_q  <= armed_q && !empty[gi] && (dcnt_q == '0);
        end else begin
          pcnt_q <= pcnt_q - REGISTER_SIZE'(1);
          if (dcnt_q != '0)
            dcnt_q <= dcnt_q - REGISTER_SIZE'(1);
        end
      end
    end

    assign dcnt[gi]          = dcnt_q;
    assign deadline_miss[gi] = miss_q;
  end

  // Strict less-than while scanning upward gives ties to the lowest index.
  always_comb begin
    winner = '0;
    best   = '1;
    found  = 1'b0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (!empty[i] && (!found || dcnt[i] < best)) begin
        winner = ID_WIDTH'(i);
        best   = dcnt[i];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      id              <= '0;
      enable          <= 1'b0;
      hasBeenConsumed <= '0;
    end else begin
      hasBeenConsumed <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            id     <= winner;
            enable <= 1'b1;
            state  <= GRANT;
          end else begin
            enable <= 1'b0;
          end
        end
        GRANT: begin
          // No preemption: only completion or the granted queue draining ends a grant.
          if (consumed) begin
            hasBeenConsumed <= NUMBER_OF_QUEUES'(1) << id;
            enable          <= 1'b0;
            state           <= IDLE;
          end else if (empty[id]) begin
            enable <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          enable <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
